mul_result_collector: RTL and testbench

Downstream stage of the bf16 multiplier tree. Captures the tree's per-lane bf16 products, which can arrive as up to 4 per cycle with no backpressure, into a FIFO in lane order. Drains them as a single 16-bit valid/ready stream for the next probabilistic-circuit node stage. Detects and flags overflow, since the tree cannot be stalled.

---
 rtl/mul_result_collector_if.sv | 21 ++
 rtl/mul_result_collector.sv | 98 +++++++++
 tb/tb_mul_result_collector.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mul_result_collector_if.sv
// Result stream bundle: per-lane products in from the multiplier tree,
// one bf16 result per beat out to the node stage.
interface mul_result_collector_if;
  logic [63:0] res_in;
  logic [3:0]  res_stb;
  logic [1:0]  mode;
  logic [15:0] out_data;
  logic [1:0]  out_lane;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output res_in, res_stb, mode, out_ready,
    input  out_data, out_lane, out_valid
  );

  modport slave (
    input  res_in, res_stb, mode, out_ready,
    output out_data, out_lane, out_valid
  );
endinterface

// File: rtl/mul_result_collector.sv
// Collects up to four bf16 tree products per cycle into a FIFO in lane order
// and drains them one per cycle; a beat that does not fit is dropped whole.
module mul_result_collector #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  mul_result_collector_if.slave    bus,
  output logic [AW:0]              level,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  logic [17:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next, off;
  logic [AW:0]   free, level_next;
  logic [3:0]    mask, acc;
  logic [2:0]    n;
  logic [15:0]   slot_data [4];
  logic [1:0]    slot_lane [4];
  logic [17:0]   head;
  logic          push, drop, pop;

  always_comb begin
    case (bus.mode)
      2'b00:        mask = 4'b1111;
      2'b01, 2'b10: mask = 4'b0011;
      default:      mask = 4'b0001;  // six_in: lane 1 is a flag, never data
    endcase
    acc = bus.res_stb & mask;
  end

  // Compact accepted lanes into consecutive write slots, lowest lane first.
  always_comb begin
    n = '0;
    for (int k = 0; k < 4; k++) begin
      slot_data[k] = '0;
      slot_lane[k] = '0;
    end
    for (int l = 0; l < 4; l++) begin
      if (acc[l]) begin
        slot_data[n[1:0]] = bus.res_in[16*l +: 16];
        slot_lane[n[1:0]] = 2'(l);
        n = n + 3'd1;
      end
    end
  end

  always_comb begin
    free        = (AW+1)'(DEPTH) - level;
    push        = (n != 3'd0) && ((AW+1)'(n) <= free);
    drop        = (n != 3'd0) && !push;
    pop         = bus.out_valid & bus.out_ready;
    level_next  = level + (push ? (AW+1)'(n) : '0) - (pop ? (AW+1)'(1) : '0);
    wr_ptr_next = wr_ptr + (push ? AW'(n) : '0);
    rd_ptr_next = rd_ptr + AW'(pop);
    off         = rd_ptr_next - wr_ptr;
    // The next head may be one of the entries written this very cycle.
    if (push && ((AW+1)'(off) < (AW+1)'(n)))
      head = {slot_lane[off[1:0]], slot_data[off[1:0]]};
    else
      head = mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < n)
          mem[wr_ptr + AW'(k)] <= {slot_lane[k], slot_data[k]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      overflow      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_lane  <= '0;
    end else begin
      wr_ptr        <= wr_ptr_next;
      rd_ptr        <= rd_ptr_next;
      level         <= level_next;
      bus.out_valid <= (level_next != '0);
      bus.out_data  <= head[15:0];
      bus.out_lane  <= head[17:16];
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_result_collector.sv
// Directed bench for mul_result_collector with hand-computed expectations.
module tb_mul_result_collector;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [4:0] level;
  logic       overflow;
  int         n_cmp = 0;
  int         n_mis = 0;

  mul_result_collector_if bus ();

  mul_result_collector #(.DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .level    (level),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] m, input logic [3:0] stb,
                      input logic [15:0] l0, input logic [15:0] l1,
                      input logic [15:0] l2, input logic [15:0] l3);
    bus.mode    = m;
    bus.res_stb = stb;
    bus.res_in  = {l3, l2, l1, l0};
    tick();
    bus.res_stb = 4'b0000;
  endtask

  task automatic drain_all();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && level != 0; i++) tick();
    bus.out_ready = 1'b0;
    check("drain_empty", level, 0);
  endtask

  logic [15:0] v [16];
  logic [15:0] q [$];
  logic [15:0] d;
  logic        do_push;
  int          pushed;
  int          guard;

  initial begin
    bus.res_in    = '0;
    bus.res_stb   = '0;
    bus.mode      = 2'b00;
    bus.out_ready = 1'b0;
    #23 rst = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_valid", bus.out_valid, 0);
      check("idle_level", level, 0);
      check("idle_ovf", overflow, 0);
    end

    // Four lanes in one beat, drained one per cycle
    bus.out_ready = 1'b1;
    beat(2'b00, 4'b1111, 16'h3F80, 16'h4000, 16'h3F00, 16'h4040);
    check("b4_valid", bus.out_valid, 1);
    v[0] = 16'h3F80; v[1] = 16'h4000; v[2] = 16'h3F00; v[3] = 16'h4040;
    for (int i = 0; i < 4; i++) begin
      check("b4_data", bus.out_data, v[i]);
      check("b4_lane", bus.out_lane, i);
      check("b4_level", level, 4 - i);
      tick();
    end
    check("b4_level_end", level, 0);
    check("b4_valid_end", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // six_in: lane 1 is a flag and discarded
    beat(2'b11, 4'b0011, 16'h4000, 16'h0001, 16'h1111, 16'h2222);
    check("m11_level", level, 1);
    check("m11_data", bus.out_data, 16'h4000);
    check("m11_lane", bus.out_lane, 0);
    drain_all();

    // three_in: lane 2 masked off
    beat(2'b01, 4'b0110, 16'h0000, 16'h3F00, 16'h5555, 16'h0000);
    check("m01_level", level, 1);
    check("m01_data", bus.out_data, 16'h3F00);
    check("m01_lane", bus.out_lane, 1);
    drain_all();

    // four_in with all strobes: only lanes 0,1
    beat(2'b10, 4'b1111, 16'hA000, 16'hA001, 16'hA002, 16'hA003);
    check("m10_level", level, 2);
    drain_all();

    // Fill to full, drop a whole beat, clear, drain in order
    for (int i = 0; i < 16; i++) v[i] = 16'h1000 + 16'(i);
    for (int b = 0; b < 4; b++)
      beat(2'b00, 4'b1111, v[4*b], v[4*b+1], v[4*b+2], v[4*b+3]);
    check("full_level", level, 16);
    check("full_ovf_pre", overflow, 0);
    beat(2'b00, 4'b1111, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD);
    check("full_level_drop", level, 16);
    check("full_ovf_set", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("full_ovf_clr", overflow, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("full_data", bus.out_data, v[i]);
      check("full_lane", bus.out_lane, i % 4);
      tick();
    end
    check("full_drained", level, 0);
    bus.out_ready = 1'b0;

    // Level 15, two-lane beat with 1 free: dropped, pop still proceeds
    for (int b = 0; b < 3; b++)
      beat(2'b00, 4'b1111, 16'h2000, 16'h2001, 16'h2002, 16'h2003);
    beat(2'b11, 4'b0001, 16'h2100, 16'h0000, 16'h0000, 16'h0000);
    beat(2'b01, 4'b0011, 16'h2200, 16'h2201, 16'h0000, 16'h0000);
    check("l15_level", level, 15);
    bus.out_ready = 1'b1;
    beat(2'b10, 4'b0011, 16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000);
    check("l15_level_after", level, 14);
    check("l15_ovf", overflow, 1);
    check("l15_head", bus.out_data, 16'h2001);
    for (int i = 0; i < 14; i++) tick();
    check("l15_drain_count", level, 0);
    bus.out_ready = 1'b0;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;

    // Random drain against a queue model, wrapping the storage twice
    pushed = 0;
    guard  = 0;
    bus.mode = 2'b11;
    while ((pushed < 37 || q.size() != 0) && guard < 2000) begin
      guard++;
      bus.out_ready = 1'($urandom_range(0, 1));
      do_push = (pushed < 37) && (q.size() < 16) && ($urandom_range(0, 1) == 1);
      d = 16'($urandom_range(0, 16'hFFFF));
      bus.res_in  = {48'h0, d};
      bus.res_stb = do_push ? 4'b0001 : 4'b0000;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("wrap_spurious", 1, 0);
        else check("wrap_data", bus.out_data, q.pop_front());
      end
      if (do_push) begin
        q.push_back(d);
        pushed++;
      end
      tick();
      bus.res_stb = 4'b0000;
      if (level != 5'(q.size())) check("wrap_level", level, q.size());
    end
    check("wrap_timeout", guard < 2000, 1);
    check("wrap_ovf", overflow, 0);
    bus.out_ready = 1'b0;

    // Asynchronous reset mid-stream
    for (int b = 0; b < 3; b++)
      beat(2'b00, 4'b1111, 16'h3000, 16'h3001, 16'h3002, 16'h3003);
    check("rst_pre_level", level, 12);
    #2 rst = 1'b0;
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_level", level, 0);
    #2 rst = 1'b1;
    tick();
    check("rst_post_valid", bus.out_valid, 0);
    check("rst_post_level", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
